// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arithmetic/move results, HI/LO forwarding,
// single-cycle multiply and a 32-iteration restoring radix-2 divider that
// holds the pipeline with a stall request until its result is ready.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    // Operation encodings (EXE_*_OP)
    localparam logic [7:0] OpNop   = 8'b0000_0000;
    localparam logic [7:0] OpAnd   = 8'b0010_0100;
    localparam logic [7:0] OpOr    = 8'b0010_0101;
    localparam logic [7:0] OpXor   = 8'b0010_0110;
    localparam logic [7:0] OpNor   = 8'b0010_0111;
    localparam logic [7:0] OpAndi  = 8'b0101_1001;
    localparam logic [7:0] OpOri   = 8'b0101_1010;
    localparam logic [7:0] OpXori  = 8'b0101_1011;
    localparam logic [7:0] OpSll   = 8'b0111_1100;
    localparam logic [7:0] OpSllv  = 8'b0000_0100;
    localparam logic [7:0] OpSrl   = 8'b0000_0010;
    localparam logic [7:0] OpSrlv  = 8'b0000_0110;
    localparam logic [7:0] OpSra   = 8'b0000_0011;
    localparam logic [7:0] OpSrav  = 8'b0000_0111;
    localparam logic [7:0] OpMfhi  = 8'b0001_0000;
    localparam logic [7:0] OpMthi  = 8'b0001_0001;
    localparam logic [7:0] OpMflo  = 8'b0001_0010;
    localparam logic [7:0] OpMtlo  = 8'b0001_0011;
    localparam logic [7:0] OpSlt   = 8'b0010_1010;
    localparam logic [7:0] OpSltu  = 8'b0010_1011;
    localparam logic [7:0] OpSlti  = 8'b0101_0111;
    localparam logic [7:0] OpSltiu = 8'b0101_1000;
    localparam logic [7:0] OpAdd   = 8'b0010_0000;
    localparam logic [7:0] OpAddu  = 8'b0010_0001;
    localparam logic [7:0] OpSub   = 8'b0010_0010;
    localparam logic [7:0] OpSubu  = 8'b0010_0011;
    localparam logic [7:0] OpAddi  = 8'b0101_0101;
    localparam logic [7:0] OpAddiu = 8'b0101_0110;
    localparam logic [7:0] OpMult  = 8'b0001_1000;
    localparam logic [7:0] OpMultu = 8'b0001_1001;
    localparam logic [7:0] OpDiv   = 8'b0001_1010;
    localparam logic [7:0] OpDivu  = 8'b0001_1011;

    // Result class encodings (EXE_RES_*)
    localparam logic [2:0] ResNop   = 3'b000;
    localparam logic [2:0] ResLogic = 3'b001;
    localparam logic [2:0] ResShift = 3'b010;
    localparam logic [2:0] ResMove  = 3'b011;
    localparam logic [2:0] ResArith = 3'b100;

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} div_state_e;

    div_state_e  state_q, state_d;
    // [64:32] partial remainder, [31:0] dividend shifting out / quotient shifting in
    logic [64:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [31:0] fwd_hi, fwd_lo;
    logic [31:0] logic_res, shift_res, arith_res, move_res;
    logic [31:0] sum, diff;
    logic        ovf;
    logic [63:0] mul_s, mul_u;
    logic        is_div, is_sdiv, div_start;
    logic [31:0] abs_r1, abs_r2;
    logic [34:0] trial;
    logic [31:0] div_quo, div_rem;

    assign is_div    = (aluop_i == OpDiv) || (aluop_i == OpDivu);
    assign is_sdiv   = (aluop_i == OpDiv);
    assign div_start = is_div && !flush_i;

    // HI/LO forwarding: MEM result is newest, then WB, then the register file
    always_comb begin
        fwd_hi = hi_i;
        fwd_lo = lo_i;
        if (mem_whilo_i) begin
            fwd_hi = mem_hi_i;
            fwd_lo = mem_lo_i;
        end else if (wb_whilo_i) begin
            fwd_hi = wb_hi_i;
            fwd_lo = wb_lo_i;
        end
    end

    // Logic unit
    always_comb begin
        logic_res = 32'd0;
        case (aluop_i)
            OpOr,  OpOri:  logic_res = reg1_i | reg2_i;
            OpAnd, OpAndi: logic_res = reg1_i & reg2_i;
            OpXor, OpXori: logic_res = reg1_i ^ reg2_i;
            OpNor:         logic_res = ~(reg1_i | reg2_i);
            default:       logic_res = 32'd0;
        endcase
    end

    // Shifter: shift amount always comes from reg1_i[4:0]
    always_comb begin
        shift_res = 32'd0;
        case (aluop_i)
            OpSll, OpSllv: shift_res = reg2_i << reg1_i[4:0];
            OpSrl, OpSrlv: shift_res = reg2_i >> reg1_i[4:0];
            OpSra, OpSrav: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            default:       shift_res = 32'd0;
        endcase
    end

    // Adder, subtractor, compares and signed-overflow detection
    always_comb begin
        sum       = reg1_i + reg2_i;
        diff      = reg1_i - reg2_i;
        arith_res = 32'd0;
        ovf       = 1'b0;
        case (aluop_i)
            OpAdd, OpAddi: begin
                arith_res = sum;
                ovf = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
            end
            OpAddu, OpAddiu: arith_res = sum;
            OpSub: begin
                arith_res = diff;
                ovf = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
            end
            OpSubu:          arith_res = diff;
            OpSlt, OpSlti:   arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OpSltu, OpSltiu: arith_res = {31'd0, reg1_i < reg2_i};
            default:         arith_res = 32'd0;
        endcase
    end

    // Moves from HI/LO see forwarded values
    always_comb begin
        move_res = 32'd0;
        case (aluop_i)
            OpMfhi:  move_res = fwd_hi;
            OpMflo:  move_res = fwd_lo;
            default: move_res = 32'd0;
        endcase
    end

    // Multipliers: 64-bit products of sign- or zero-extended operands
    always_comb begin
        mul_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
        mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};
    end

    // Divider state register; rst or flush abandons any divide in progress
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Divider next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    state_d = (reg2_i == 32'd0) ? StByZero : StOn;
                end
            end
            StByZero: state_d = StEnd;
            StOn:     state_d = (cnt_q == 5'd31) ? StEnd : StOn;
            StEnd:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Divider datapath registers
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            work_q    <= 65'd0;
            dvs_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Divider datapath next state: operand capture and one restoring step per cycle
    always_comb begin
        abs_r1    = (is_sdiv && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
        abs_r2    = (is_sdiv && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
        // Shifted partial remainder minus divisor; bit 34 set means it went negative
        trial     = {1'b0, work_q[64:31]} - {3'd0, dvs_q};
        work_d    = work_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            StIdle: begin
                if (div_start && reg2_i != 32'd0) begin
                    work_d    = {33'd0, abs_r1};
                    dvs_d     = abs_r2;
                    cnt_d     = 5'd0;
                    neg_quo_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                    neg_rem_d = is_sdiv && reg1_i[31];
                end else if (div_start) begin
                    work_d    = 65'd0;
                    dvs_d     = 32'd0;
                    cnt_d     = 5'd0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                end
            end
            StOn: begin
                if (!trial[34]) begin
                    work_d = {trial[32:0], work_q[30:0], 1'b1};
                end else begin
                    work_d = {work_q[63:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
            end
            StByZero, StEnd: ;
            default: ;
        endcase
    end

    // Sign fix-up of the magnitude result
    always_comb begin
        div_quo = neg_quo_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
        div_rem = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
    end

    // Output logic: GPR result, HI/LO write and stall request
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i && !ovf;
        wdata_o    = 32'd0;
        whilo_o    = 1'b0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        stallreq_o = is_div && (state_q != StEnd);
        case (alusel_i)
            ResLogic: wdata_o = logic_res;
            ResShift: wdata_o = shift_res;
            ResArith: wdata_o = arith_res;
            ResMove:  wdata_o = move_res;
            ResNop:   wdata_o = 32'd0;
            default:  wdata_o = 32'd0;
        endcase
        case (aluop_i)
            OpMult: begin
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_s;
            end
            OpMultu: begin
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_u;
            end
            OpMthi: begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = fwd_lo;
            end
            OpMtlo: begin
                whilo_o = 1'b1;
                hi_o    = fwd_hi;
                lo_o    = reg1_i;
            end
            OpDiv, OpDivu: begin
                if (state_q == StEnd) begin
                    whilo_o = 1'b1;
                    hi_o    = div_rem;
                    lo_o    = div_quo;
                end
            end
            OpNop:   ;
            default: ;
        endcase
        if (rst) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            whilo_o    = 1'b0;
            hi_o       = 32'd0;
            lo_o       = 32'd0;
            stallreq_o = 1'b0;
        end
    end

endmodule
